// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_if
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, busy, done, zero
  );

endinterface

// File: rtl/countdown_timer_prescale_tick.sv
// Prescaler: while en, counts 0..PRESCALE-1 and flags tick on the last value before wrapping.
module prescale_tick #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/auto-reload modes and pause hold.
// Define TIMER_PRESCALE_EN to decrement once every PRESCALE clocks instead of every clock.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE must be >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  // Prescaler idles at zero outside RUN and freezes while pausing/holding.
  prescale_tick #(.PRESCALE(PRESCALE)) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.load || (state == IDLE)),
    .en   ((state == RUN) && !bus.pause),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        count_q  <= bus.load_val;
        reload_q <= bus.load_val;
        state    <= IDLE;
        busy_q   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && (count_q != '0)) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state <= HOLD;
            end else if (tick) begin
              if (count_q > WIDTH'(1)) begin
                count_q <= count_q - WIDTH'(1);
              end else begin
                // Terminal count; a zero reload value falls back to one-shot.
                done_q <= 1'b1;
                if (bus.auto_reload && (reload_q != '0)) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          HOLD: begin
            if (!bus.pause) begin
              state <= RUN;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default build, or TIMER_PRESCALE_EN).
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  countdown_timer_if #(.WIDTH(3)) bus ();

  countdown_timer #(.WIDTH(3), .PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [2:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic expect_state(input string tag, input int c, input bit b, input bit d);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".busy"},  32'(bus.busy),  32'(b));
    check({tag, ".done"},  32'(bus.done),  32'(d));
    check({tag, ".zero"},  32'(bus.zero),  32'(c == 0));
  endtask

  initial begin
    rst             = 1'b1;
    bus.load        = 1'b0;
    bus.load_val    = '0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
    repeat (10) step();
    expect_state("reset", 0, 1'b0, 1'b0);
    rst = 1'b0;
    do_start();
    expect_state("start_at_zero", 0, 1'b0, 1'b0);

`ifndef TIMER_PRESCALE_EN
    // One-shot from 5
    load_val(3'd5);
    expect_state("os_load", 5, 1'b0, 1'b0);
    do_start();
    expect_state("os_start", 5, 1'b1, 1'b0);
    for (int c = 4; c >= 1; c--) begin
      step();
      expect_state("os_run", c, 1'b1, 1'b0);
    end
    step();
    expect_state("os_term", 0, 1'b0, 1'b1);
    step();
    expect_state("os_after", 0, 1'b0, 1'b0);

    // Auto-reload from 3, then drop auto_reload mid-run
    load_val(3'd3);
    bus.auto_reload = 1'b1;
    do_start();
    expect_state("ar_start", 3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      expect_state("ar_run", (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3, 1'b1, (i % 3 == 2));
    end
    bus.auto_reload = 1'b0;
    step();
    expect_state("ar_off2", 2, 1'b1, 1'b0);
    step();
    expect_state("ar_off1", 1, 1'b1, 1'b0);
    step();
    expect_state("ar_offterm", 0, 1'b0, 1'b1);

    // Pause at count 4 for 4 cycles
    load_val(3'd6);
    do_start();
    step();
    step();
    expect_state("ps_pre", 4, 1'b1, 1'b0);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state("ps_hold", 4, 1'b1, 1'b0);
    end
    bus.pause = 1'b0;
    step();
    expect_state("ps_resume", 4, 1'b1, 1'b0);
    for (int c = 3; c >= 1; c--) begin
      step();
      expect_state("ps_run", c, 1'b1, 1'b0);
    end
    step();
    expect_state("ps_term", 0, 1'b0, 1'b1);

    // Load mid-run at count 2
    load_val(3'd5);
    do_start();
    repeat (3) step();
    expect_state("lm_pre", 2, 1'b1, 1'b0);
    load_val(3'd7);
    expect_state("lm_load", 7, 1'b0, 1'b0);

    // Load on the terminal edge suppresses done
    load_val(3'd2);
    do_start();
    step();
    expect_state("lt_pre", 1, 1'b1, 1'b0);
    load_val(3'd4);
    expect_state("lt_load", 4, 1'b0, 1'b0);
    step();
    expect_state("lt_after", 4, 1'b0, 1'b0);

    // All-ones load counts the full range
    load_val(3'd7);
    do_start();
    repeat (6) step();
    expect_state("max_pre", 1, 1'b1, 1'b0);
    step();
    expect_state("max_term", 0, 1'b0, 1'b1);

    // Reset mid-run at count 3
    load_val(3'd5);
    do_start();
    step();
    step();
    expect_state("rm_pre", 3, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    expect_state("rm_reset", 0, 1'b0, 1'b0);
    rst = 1'b0;
    do_start();
    expect_state("rm_start", 0, 1'b0, 1'b0);
`else
    begin
      int edges;
      load_val(3'd2);
      do_start();
      edges = 1;
      while (!bus.done && edges < 20) begin
        step();
        edges++;
      end
      check("pre_done_seen", 32'(bus.done), 32'd1);
      check("pre_latency", 32'(edges), 32'd9);
      check("pre_count", 32'(bus.count), 32'd0);
      step();
      expect_state("pre_after", 0, 1'b0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter and timer: the counterpart of the team's free-running up-counter.
- Counts a programmed value down to zero and pulses `done` at terminal count.
- Supports one-shot and auto-reload modes, plus a pause hold.
- Sits beside the lab counters as a reusable delay/timeout source for FSM and testbench experiments.

Parameters:
- WIDTH, 3: counter and load-value width in bits.
- PRESCALE, 4: clocks per decrement; used only when TIMER_PRESCALE_EN is defined; legal range ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture load_val into count and reload register.
- load_val  input  WIDTH  value to load.
- start  input  1  begin counting from IDLE.
- pause  input  1  freeze counting while high (RUN/HOLD only).
- auto_reload  input  1  reload on terminal count instead of stopping.
- count  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse at terminal count.
- zero  output  1  count == 0 (combinational from count register).

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: count=0, reload_reg=0, state=IDLE, busy=0, done=0, zero=1. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, HOLD. busy is registered and equals (state!=IDLE).
- Priority per edge: rst > load > terminal/decrement > start.
- load (any state):
  - count<=load_val and reload_reg<=load_val.
  - state<=IDLE, done<=0.
  - Any in-flight terminal count is suppressed.
- start:
  - In IDLE with count!=0: state<=RUN; no decrement on that edge.
  - In IDLE with count==0: ignored; no done.
  - In RUN or HOLD: ignored.
- RUN with pause=0 (decrement enable = tick; tick=1 every cycle unless prescaled):
  - count>1: count<=count-1.
  - count==1, auto_reload=0: count<=0, state<=IDLE, done<=1.
  - count==1, auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN, done<=1.
  - count==1, auto_reload=1 and reload_reg==0: treated as auto_reload=0.
- RUN with pause=1: state<=HOLD, count frozen.
- HOLD:
  - count frozen, busy=1.
  - pause=0: state<=RUN; decrementing resumes on the following edge.
- done is high exactly one cycle; it is low on every other edge.
- Latency: from start sampled with count=N to the done pulse is N+1 edges (one-shot, no pause). Auto-reload period is N edges per done.
- No wrap-around: count never decrements below 0. An all-ones load_val is legal.
- Toggling auto_reload mid-run takes effect at the next terminal edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A prescaler counter 0..PRESCALE-1 runs only in RUN; tick=1 when it equals PRESCALE-1, then it wraps to 0.
  - The prescaler clears on rst, load, start, and entry to IDLE.
  - It is frozen in HOLD.
  - Decrement, terminal and done occur only on tick edges.
  - One-shot latency becomes N*PRESCALE+1 edges.
- Undefined:
  - tick is constant 1; the PRESCALE parameter is ignored.
  - Timing is exactly as specified in Behaviour.

Decomposition:
- Package countdown_pkg: state typedef (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and DEFAULT_WIDTH=3 constant.
- Sub-module prescale_tick (WIDTH derived from PRESCALE; inputs clk, rst, clr, en; output tick).
  - Instantiated only under TIMER_PRESCALE_EN.

Test Plan:
1. Reset: rst=1 for 100 ns with the clock toggling every 5 ns → count=0, busy=0, done=0, zero=1; start with count=0 → stays IDLE.
2. One-shot: load 5, then start, auto_reload=0 → count 5,5,4,3,2,1,0; done high one cycle as count hits 0; then busy=0, zero=1.
3. Auto-reload: load 3, start, auto_reload=1 → count 3,2,1,3,2,1,...; done every 3rd edge; zero never asserts; busy stays 1.
4. Pause: one-shot from 6, assert pause for 4 cycles at count=4 → count holds 4, busy=1, no done; release → 3,2,1,0 with done.
5. Load mid-run: at count=2, load 7 → next edge count=7, IDLE, no done; simultaneous load and terminal edge → count=load_val, done=0.
6. Reset mid-run: rst=1 at count=3 → next edge count=0, IDLE, done=0. With TIMER_PRESCALE_EN and PRESCALE=4: load 2, start → done 9 edges after start.
